// File: rtl/spi_mem_arbiter_if.sv
// spi_mem_arbiter_if: SPI, debug and RAM signals of the shared-RAM arbiter
interface spi_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              spi_ack;
  logic [DATA_W-1:0] spi_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata, dbg_req, dbg_addr, mem_rdata,
    output spi_ack, spi_rdata, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata, dbg_req, dbg_addr, mem_rdata,
    input  spi_ack, spi_rdata, dbg_ack, dbg_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one RAM between SPI (r/w) and a starvation-guarded debug reader
module spi_mem_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  spi_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
  state_t     state;
  logic [3:0] streak;
  logic       owner_dbg;
  logic       op_we;
  logic       dbg_win;
  always_comb dbg_win = bus.dbg_req & (!bus.spi_req | streak == 4'(STARVE_LIMIT));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      owner_dbg     <= 1'b0;
      op_we         <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.spi_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.spi_rdata <= {DATA_W{1'b0}};
      bus.dbg_rdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_en <= 1'b0;
          if (bus.spi_req | bus.dbg_req) begin
            owner_dbg     <= dbg_win;
            op_we         <= !dbg_win & bus.spi_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= !dbg_win & bus.spi_we;
            bus.mem_addr  <= dbg_win ? bus.dbg_addr : bus.spi_addr;
            bus.mem_wdata <= dbg_win ? {DATA_W{1'b0}} : bus.spi_wdata;
            // SPI can only win a contested round while below the limit, so +1 never overshoots
            streak        <= (!dbg_win & bus.dbg_req) ? streak + 4'd1 : 4'd0;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          if (!op_we && owner_dbg) bus.dbg_rdata <= bus.mem_rdata;
          if (!op_we && !owner_dbg) bus.spi_rdata <= bus.mem_rdata;
          bus.spi_ack <= !owner_dbg;
          bus.dbg_ack <= owner_dbg;
          state       <= DONE;
        end
        default: begin
          bus.spi_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: vector table, directed corner cases and random traffic vs a transaction model
module tb_spi_mem_arbiter;
  localparam int STARVE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_mem_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();
  spi_mem_arbiter #(.ADDR_W(6), .DATA_W(8), .STARVE_LIMIT(STARVE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] ram [64];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end

  // Transaction-level reference: phase counts cycles since the grant edge (0 = free)
  logic [7:0] mm [64];
  int phase = 0, streak = 0;
  logic m_dbg = 0, m_we = 0;
  logic [5:0] m_addr = 0;
  logic [7:0] m_wdata = 0, e_srd = 0, e_drd = 0;
  always @(posedge clk) begin
    if (phase == 1 && m_we) mm[m_addr] = m_wdata;
    if (!rst_n) begin
      phase = 0; streak = 0; m_dbg = 0; m_we = 0; m_addr = 0; m_wdata = 0; e_srd = 0; e_drd = 0;
    end else if (phase == 0) begin
      if (bus.spi_req || bus.dbg_req) begin
        m_dbg = bus.dbg_req && (!bus.spi_req || streak >= STARVE);
        streak = (!m_dbg && bus.dbg_req) ? streak + 1 : 0;
        m_we = !m_dbg && bus.spi_we;
        m_addr = m_dbg ? bus.dbg_addr : bus.spi_addr;
        m_wdata = m_dbg ? 8'h00 : bus.spi_wdata;
        phase = 1;
      end
    end else begin
      if (phase == 2 && !m_we) begin
        if (m_dbg) e_drd = mm[m_addr];
        else e_srd = mm[m_addr];
      end
      phase = (phase + 1) % 4;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("mem_en", 32'(bus.mem_en), 32'(phase == 1));
    chk("mem_we", 32'(bus.mem_we), 32'(phase == 1 && m_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    chk("busy", 32'(bus.busy), 32'(phase != 0));
    chk("spi_ack", 32'(bus.spi_ack), 32'(phase == 3 && !m_dbg));
    chk("dbg_ack", 32'(bus.dbg_ack), 32'(phase == 3 && m_dbg));
    chk("spi_rdata", 32'(bus.spi_rdata), 32'(e_srd));
    chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(e_drd));
    chk("ack_excl", 32'(bus.spi_ack & bus.dbg_ack), 32'd0);
  endtask

  typedef struct {
    logic s_req, d_req, s_we;
    logic [5:0] s_addr;
    logic [7:0] s_wd;
    logic [5:0] d_addr;
    logic exp_dbg, exp_we;
    logic [5:0] exp_addr;
    logic [7:0] exp_wd;
  } vec_t;
  vec_t tbl [9];
  logic got [$];

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 8'($urandom);
      mm[i] = ram[i];
    end
    ram[6'h3F] = 8'h5C;
    mm[6'h3F] = 8'h5C;
    bus.mem_rdata = 8'h00;
    bus.spi_req = 0; bus.spi_we = 0; bus.spi_addr = 0; bus.spi_wdata = 0;
    bus.dbg_req = 0; bus.dbg_addr = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 6'h12, 8'hA5, 6'h00, 1'b0, 1'b1, 6'h12, 8'hA5};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 6'h12, 8'h00, 6'h00, 1'b0, 1'b0, 6'h12, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 6'h3F, 1'b1, 1'b0, 6'h3F, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 6'h01, 8'h11, 6'h20, 1'b0, 1'b1, 6'h01, 8'h11};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 6'h02, 8'hFF, 6'h20, 1'b0, 1'b0, 6'h02, 8'hFF};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 6'h03, 8'h00, 6'h20, 1'b0, 1'b0, 6'h03, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 6'h04, 8'h00, 6'h20, 1'b0, 1'b0, 6'h04, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 6'h05, 8'h33, 6'h21, 1'b1, 1'b0, 6'h21, 8'h00};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 6'h07, 8'h44, 6'h22, 1'b1, 1'b0, 6'h22, 8'h00};

    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_spi_rdata", 32'(bus.spi_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      bus.spi_req = tbl[i].s_req; bus.dbg_req = tbl[i].d_req; bus.spi_we = tbl[i].s_we;
      bus.spi_addr = tbl[i].s_addr; bus.spi_wdata = tbl[i].s_wd; bus.dbg_addr = tbl[i].d_addr;
      tick();
      chk($sformatf("v%0d_en", i), 32'(bus.mem_en), 32'd1);
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].exp_we));
      chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("v%0d_wd", i), 32'(bus.mem_wdata), 32'(tbl[i].exp_wd));
      tick(); tick();
      chk($sformatf("v%0d_sack", i), 32'(bus.spi_ack), 32'(!tbl[i].exp_dbg));
      chk($sformatf("v%0d_dack", i), 32'(bus.dbg_ack), 32'(tbl[i].exp_dbg));
      if (i == 1) chk("rd_a5", 32'(bus.spi_rdata), 32'hA5);
      if (i == 2) begin
        chk("dbg_5c", 32'(bus.dbg_rdata), 32'h5C);
        chk("spi_kept", 32'(bus.spi_rdata), 32'hA5);
      end
      bus.spi_req = 0; bus.dbg_req = 0;
      tick();
      chk($sformatf("v%0d_idle", i), 32'(bus.busy), 32'd0);
    end

    // both held continuously from streak 0
    bus.spi_req = 1; bus.spi_we = 0; bus.spi_addr = 6'h10; bus.dbg_req = 1; bus.dbg_addr = 6'h3F;
    got.delete();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.spi_ack) got.push_back(1'b0);
      if (bus.dbg_ack) got.push_back(1'b1);
    end
    chk("cont_n", 32'(got.size()), 32'd10);
    for (int g = 0; g < 10 && g < got.size(); g++) chk($sformatf("cont_g%0d", g), 32'(got[g]), 32'(g % 5 == 4));
    bus.spi_req = 0; bus.dbg_req = 0;
    tick(); tick(); tick(); tick();

    // SPI alone for 3 transactions, then contention
    bus.spi_req = 1;
    for (int c = 0; c < 12; c++) tick();
    bus.dbg_req = 1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.spi_ack) got.push_back(1'b0);
      if (bus.dbg_ack) got.push_back(1'b1);
    end
    chk("late_n", 32'(got.size()), 32'd5);
    for (int g = 0; g < 5 && g < got.size(); g++) chk($sformatf("late_g%0d", g), 32'(got[g]), 32'(g == 4));
    bus.spi_req = 0; bus.dbg_req = 0;
    tick(); tick(); tick(); tick();

    // reset sampled at the edge ending ACCESS of a write
    bus.spi_req = 1; bus.spi_we = 1; bus.spi_addr = 6'h05; bus.spi_wdata = 8'h77;
    tick();
    chk("rw_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rw_ram", 32'(ram[5]), 32'h77);
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_outs", {bus.mem_en, bus.mem_we, bus.spi_ack, bus.dbg_ack, bus.mem_addr, bus.mem_wdata, bus.spi_rdata}, 32'd0);
    rst_n = 1'b1; bus.spi_req = 0;
    tick();
    chk("rw_noack", 32'(bus.spi_ack), 32'd0);
    bus.spi_req = 1; bus.spi_we = 0;
    tick(); tick(); tick();
    chk("rw_rd_ack", 32'(bus.spi_ack), 32'd1);
    chk("rw_rd_data", 32'(bus.spi_rdata), 32'h77);
    bus.spi_req = 0;
    tick();

    // req dropped during ACCESS
    bus.spi_req = 1; bus.spi_we = 0; bus.spi_addr = 6'h12;
    tick();
    bus.spi_req = 0;
    tick(); tick();
    chk("drop_ack", 32'(bus.spi_ack), 32'd1);
    tick();
    chk("drop_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("drop_noreq", 32'(bus.mem_en | bus.busy), 32'd0);

    // random traffic; requesters drop on ack
    for (int c = 0; c < 600; c++) begin
      tick();
      if (bus.spi_ack) bus.spi_req = 0;
      else if (!bus.spi_req && $urandom_range(0, 2) == 0) begin
        bus.spi_req = 1; bus.spi_we = 1'($urandom); bus.spi_addr = 6'($urandom); bus.spi_wdata = 8'($urandom);
      end
      if (bus.dbg_ack) bus.dbg_req = 0;
      else if (!bus.dbg_req && $urandom_range(0, 3) == 0) begin
        bus.dbg_req = 1; bus.dbg_addr = 6'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Arbitrates one single-port synchronous register RAM between two requesters. The SPI command engine has read/write access and normal priority. The debug nibble-readout path is read-only with a starvation guard. The block sits between the SPI slave datapath, the debug_addr/debug_data readout logic and the shared RAM, and sequences every RAM access through a fixed 4-state handshake.

Parameters:
ADDR_W, 6, RAM address width (64 locations)
DATA_W, 8, RAM data width
STARVE_LIMIT, 4, consecutive contested SPI grants after which debug wins the next contested arbitration (1..15)

Ports:
clk  input  1  design clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
spi_req  input  1  SPI request, level; held until spi_ack
spi_we  input  1  1=write, 0=read; stable while spi_req high
spi_addr  input  ADDR_W  SPI address
spi_wdata  input  DATA_W  SPI write data
spi_ack  output  1  one-cycle completion pulse to SPI
spi_rdata  output  DATA_W  SPI read data; valid when spi_ack=1, held until next SPI read
dbg_req  input  1  debug read request, level; held until dbg_ack
dbg_addr  input  ADDR_W  debug address
dbg_ack  output  1  one-cycle completion pulse to debug
dbg_rdata  output  DATA_W  debug read data; valid when dbg_ack=1, held until next debug read
mem_en  output  1  RAM enable, registered
mem_we  output  1  RAM write enable, registered
mem_addr  output  ADDR_W  RAM address, registered
mem_wdata  output  DATA_W  RAM write data, registered
mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en&!mem_we
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, spi_ack, dbg_ack, spi_rdata, dbg_rdata, busy. Streak counter = 0, owner = SPI.
- States: IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE. No other transitions except reset.
- IDLE: on an edge with any req high, pick a winner:
  - Winner loads mem_addr/mem_we/mem_wdata from the winner's inputs. Debug always gives we=0 and wdata=0.
  - mem_en<=1, go ACCESS.
  - With no req, stay in IDLE and leave mem_* unchanged except mem_en=0.
- Arbitration: SPI wins if only spi_req is high, or if both are high and streak < STARVE_LIMIT. Debug wins if only dbg_req is high, or if both are high and streak == STARVE_LIMIT.
- Streak update: increments (saturating at STARVE_LIMIT) when SPI wins with dbg_req high. Clears when debug wins or when SPI wins with dbg_req low.
- ACCESS: mem_en is high for exactly this cycle. Edge: mem_en<=0, mem_we<=0, go CAPTURE.
- CAPTURE: mem_rdata is valid.
  - Edge, read: winner's rdata register <= mem_rdata.
  - Edge, write: spi_rdata is unchanged.
  - Edge, either case: winner's ack<=1, go DONE.
- DONE: the winner's ack is high for exactly this cycle. The requester drops req on this edge. Edge: ack<=0, go IDLE.
- Req is ignored in ACCESS, CAPTURE and DONE. A req still high in IDLE after DONE is a new transaction.
- Latency: req sampled high at edge E0 in IDLE gives mem_en high in cycle E0..E1 and ack high in cycle E2..E3. Maximum throughput is one transaction per 4 cycles.
- Never both acks high in the same cycle. Never mem_en high outside ACCESS.
- Req dropped before ack (protocol violation): the transaction still completes and ack still pulses.
- Reset mid-transaction: returns to IDLE next edge and the ack is never issued. If reset is first sampled at the edge ending ACCESS, the RAM also sees mem_en/mem_we at that edge, so a write may commit. The requester must reissue after reset.
- Address/data arithmetic: no width conversion. Addresses wider than ADDR_W are truncated by the instantiating level, not here.

Test Plan:
- SPI write 0xA5 to addr 0x12, then SPI read of addr 0x12: mem_en high 1 cycle after req edge with mem_we=1, mem_addr=0x12, mem_wdata=0xA5; read gives spi_ack 3 cycles after req and spi_rdata=0xA5; dbg_ack stays 0.
- Debug-only read of addr 0x3F with RAM model holding 0x5C: mem_we=0, dbg_ack pulses one cycle at E0+3, dbg_rdata=0x5C; spi_rdata unchanged.
- spi_req and dbg_req both held high continuously, STARVE_LIMIT=4: grant order S,S,S,S,D,S,S,S,S,D; every transaction is 4 cycles; acks are never coincident.
- SPI alone held high 3 transactions, then debug raised and both held: streak is 0 at contention start, so SPI wins 4 more contested grants before debug.
- rst_n low on the cycle mem_en=1 (write 0x77 to addr 0x05): RAM shows the write, no spi_ack, and next cycle busy=0 with all outputs 0; a subsequent read of 0x05 returns 0x77.
- spi_req dropped during ACCESS: spi_ack still pulses at E0+3; state returns to IDLE; no second transaction.
